// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and round-robin pick function for the mux arbiter
package arb_pkg;

  localparam int unsigned MAX_N = 256;

  typedef enum logic {
    ARB_IDLE_RR = 1'b0,
    ARB_LOCKED  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic        found;
    logic [31:0] idx;
  } pick_t;

  // First valid index at or after ptr wins; otherwise the lowest valid index below ptr.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] valid,
                                    input int unsigned      ptr,
                                    input int unsigned      n);
    pick_t lo;
    pick_t hi;
    lo = '0;
    hi = '0;
    for (int k = MAX_N - 1; k >= 0; k--) begin
      if (k < int'(n) && valid[k]) begin
        if (k >= int'(ptr)) begin
          hi.found = 1'b1;
          hi.idx   = 32'(k);
        end else begin
          lo.found = 1'b1;
          lo.idx   = 32'(k);
        end
      end
    end
    return hi.found ? hi : lo;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// rtl/rr_mux_arbiter_mux.sv - parameterized N-to-1 data mux
module rr_mux_arbiter_mux #(
  parameter int BitWidth = 8,
  parameter int N        = 4,
  parameter int SelWidth = $clog2(N)
) (
  input  logic [BitWidth-1:0] data_i [N-1:0],
  input  logic [SelWidth-1:0] sel_i,
  output logic [BitWidth-1:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_i == SelWidth'(k)) data_o = data_i[k];
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter with packet lock driving a shared mux
// into a single registered output slot.
module rr_mux_arbiter
  import arb_pkg::*;
#(
  parameter  int BitWidth = 8,
  parameter  int N        = 4,
  localparam int SelWidth = $clog2(N)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N-1:0]        req_valid_i,
  input  logic [N-1:0]        req_last_i,
  input  logic [BitWidth-1:0] req_data_i [N-1:0],
  output logic [N-1:0]        req_ready_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [BitWidth-1:0] out_data_o,
  output logic                out_last_o,
  output logic [SelWidth-1:0] out_sel_o
);

  if (N < 2 || N > 256) begin : g_bad_n
    $error("rr_mux_arbiter: N must be in 2..256");
  end

  arb_state_e          state_q, state_d;
  logic [SelWidth-1:0] ptr_q, ptr_d;
  logic [SelWidth-1:0] lk_q, lk_d;
  logic [SelWidth-1:0] g;
  logic                load;
  logic                gnt_valid;
  logic                accept;
  logic                g_last;
  logic [BitWidth-1:0] g_data;
  pick_t               pick;

  assign load   = !out_valid_o || out_ready_i;
  assign g_last = req_last_i[g];

  always_comb begin
    pick = rr_pick(MAX_N'(req_valid_i), 32'(ptr_q), 32'(N));
  end

  // Grant/ready: a locked packet owns the mux even while its valid is low.
  always_comb begin
    g           = '0;
    gnt_valid   = 1'b0;
    req_ready_o = '0;
    if (state_q == ARB_LOCKED) begin
      g         = lk_q;
      gnt_valid = req_valid_i[lk_q];
    end else begin
      g         = SelWidth'(pick.idx);
      gnt_valid = pick.found;
    end
    accept = rst_ni && load && gnt_valid;
    if (accept) req_ready_o[g] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lk_d    = lk_q;
    if (accept) begin
      if (g_last) begin
        state_d = ARB_IDLE_RR;
        ptr_d   = (g == SelWidth'(N - 1)) ? '0 : g + 1'b1;
      end else begin
        state_d = ARB_LOCKED;
        lk_d    = g;
      end
    end
  end

  rr_mux_arbiter_mux #(
    .BitWidth (BitWidth),
    .N        (N),
    .SelWidth (SelWidth)
  ) u_mux (
    .data_i (req_data_i),
    .sel_i  (g),
    .data_o (g_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ARB_IDLE_RR;
      ptr_q       <= '0;
      lk_q        <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
      out_sel_o   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lk_q    <= lk_d;
      if (load) begin
        out_valid_o <= accept;
        if (accept) begin
          out_data_o <= g_data;
          out_last_o <= g_last;
          out_sel_o  <= g;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - directed self-checking bench for rr_mux_arbiter
module tb_rr_mux_arbiter;

  localparam int BW = 8;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_last;
  logic [BW-1:0] req_data [NR-1:0];
  logic [NR-1:0] req_ready;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic          out_last;
  logic [1:0]    out_sel;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.BitWidth(BW), .N(NR)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_last_i  (req_last),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .out_sel_o   (out_sel)
  );

  // Requesters must not change a beat that is still waiting for ready.
  logic [NR-1:0] pend = '0;
  logic [BW-1:0] hd [NR-1:0];
  logic [NR-1:0] hl;
  always @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NR; k++) begin
        if (pend[k] && req_valid[k])
          assert (req_data[k] == hd[k] && req_last[k] == hl[k])
            else $error("requester %0d changed a pending beat", k);
      end
    end
    pend <= rst_n ? (req_valid & ~req_ready) : '0;
    for (int k = 0; k < NR; k++) hd[k] <= req_data[k];
    hl <= req_last;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] sel,
                         input logic [7:0] data, input logic last);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".sel"},   32'(out_sel),   32'(sel));
    chk({tag, ".data"},  32'(out_data),  32'(data));
    chk({tag, ".last"},  32'(out_last),  32'(last));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    out_ready = 1'b1;
    req_valid = '1;
    req_last  = '1;
    for (int k = 0; k < NR; k++) req_data[k] = 8'(8'h10 + k);

    // reset with every requester valid
    repeat (3) step();
    #1;
    chk_out("reset", 1'b0, 2'd0, 8'h00, 1'b0);
    chk("reset.ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    #1 chk("first_grant", 32'(req_ready), 32'b0001);

    // fairness across single-beat packets
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      chk_out("fair", 1'b1, 2'(i % 4), 8'(8'h10 + i % 4), 1'b1);
      chk("fair.ready", 32'(req_ready), 32'(1 << ((i + 1) % 4)));
    end

    req_valid = '0;
    #1 chk("idle.ready", 32'(req_ready), 32'h0);
    step();
    #1 chk("idle.bubble", 32'(out_valid), 32'h0);

    // packet lock on req1 with a valid gap
    req_valid   = '1;
    req_last    = 4'b1101;
    req_data[1] = 8'hA0;
    #1 chk("lock.ready0", 32'(req_ready), 32'b0010);
    step();
    #1 chk_out("lock.b0", 1'b1, 2'd1, 8'hA0, 1'b0);
    req_valid   = 4'b1101;
    req_data[1] = 8'hA1;
    #1 chk("lock.gap_ready", 32'(req_ready), 32'h0);
    step();
    #1 chk("lock.gap_bubble", 32'(out_valid), 32'h0);
    req_valid = '1;
    #1 chk("lock.ready1", 32'(req_ready), 32'b0010);
    step();
    #1 chk_out("lock.b1", 1'b1, 2'd1, 8'hA1, 1'b0);
    req_data[1] = 8'hA2;
    req_last    = '1;
    #1 chk("lock.ready2", 32'(req_ready), 32'b0010);
    step();
    #1 chk_out("lock.b2", 1'b1, 2'd1, 8'hA2, 1'b1);
    chk("lock.next_ready", 32'(req_ready), 32'b0100);
    req_data[1] = 8'h11;
    step();
    #1 chk_out("lock.after", 1'b1, 2'd2, 8'h12, 1'b1);

    // backpressure with a full slot
    out_ready = 1'b0;
    #1 chk("bp.ready", 32'(req_ready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      chk_out("bp.hold", 1'b1, 2'd2, 8'h12, 1'b1);
      chk("bp.hold_ready", 32'(req_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1 chk("bp.release_ready", 32'(req_ready), 32'b1000);
    step();
    #1 chk_out("bp.next", 1'b1, 2'd3, 8'h13, 1'b1);

    // wrap from ptr=3 back to 0
    req_valid = 4'b0100;
    #1 chk("wrap.setup_ready", 32'(req_ready), 32'b0100);
    step();
    #1 chk_out("wrap.setup", 1'b1, 2'd2, 8'h12, 1'b1);
    req_valid = 4'b1001;
    #1 chk("wrap.ready3", 32'(req_ready), 32'b1000);
    step();
    #1 chk_out("wrap.g3", 1'b1, 2'd3, 8'h13, 1'b1);
    chk("wrap.ready0", 32'(req_ready), 32'b0001);
    step();
    #1 chk_out("wrap.g0", 1'b1, 2'd0, 8'h10, 1'b1);

    // async reset in the middle of a req2 packet
    req_valid   = 4'b0100;
    req_last    = 4'b0000;
    req_data[2] = 8'hC0;
    #1 chk("areset.ready", 32'(req_ready), 32'b0100);
    step();
    #1 chk_out("areset.locked", 1'b1, 2'd2, 8'hC0, 1'b0);
    #2;
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    chk_out("areset.now", 1'b0, 2'd0, 8'h00, 1'b0);
    chk("areset.ready_low", 32'(req_ready), 32'h0);
    step();
    #1 chk("areset.held", 32'(out_valid), 32'h0);
    rst_n       = 1'b1;
    req_valid   = '1;
    req_last    = '1;
    req_data[2] = 8'h12;
    #1;
    chk("areset.grant", 32'(req_ready), 32'b0001);
    chk("areset.no_emit", 32'(out_valid), 32'h0);
    step();
    #1 chk_out("areset.first", 1'b1, 2'd0, 8'h10, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
